merge_2_ctrl: RTL and testbench

//  Issue scheduler for the 2-element bitonic merge network. Arbitrates between two sorted

---
 rtl/merge_2_ctrl.sv | 118 +++++++++++
 tb/tb_merge_2_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/merge_2_ctrl.sv
// merge_2_ctrl: issue scheduler feeding a 2-element bitonic merge network from two sorted tuple FIFOs.
// Ties go to A; a tuple with upper element 0 terminates its stream and is consumed without being issued.
module merge_2_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [2*DATA_W-1:0]   i_a_data,
    input  logic                  i_a_empty,
    output logic                  o_a_deq,
    input  logic [2*DATA_W-1:0]   i_b_data,
    input  logic                  i_b_empty,
    output logic                  o_b_deq,
    input  logic                  i_out_full,
    output logic [2*DATA_W-1:0]   o_elems,
    output logic                  o_stall,
    output logic                  o_switch_output,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN_A, DRAIN_B, FLUSH, DONE} state_t;
    state_t state_q, state_d;
    logic a_term_q, a_term_d, b_term_q, b_term_d;
    logic [2*DATA_W-1:0] elems_q, elems_d;
    logic stall_q, stall_d, sw_q, sw_d;
    logic a_tz, b_tz, a_ok, b_ok, a_le_b;
    assign a_tz   = i_a_data[2*DATA_W-1:DATA_W] == '0;
    assign b_tz   = i_b_data[2*DATA_W-1:DATA_W] == '0;
    assign a_ok   = ~i_a_empty & ~i_out_full;
    assign b_ok   = ~i_b_empty & ~i_out_full;
    assign a_le_b = i_a_data[2*DATA_W-1:DATA_W] <= i_b_data[2*DATA_W-1:DATA_W];
    always_comb begin
        state_d  = state_q;
        a_term_d = a_term_q;
        b_term_d = b_term_q;
        elems_d  = elems_q;
        sw_d     = sw_q;
        stall_d  = 1'b1;
        o_a_deq  = 1'b0;
        o_b_deq  = 1'b0;
        case (state_q)
            IDLE, DONE: if (i_start) begin
                state_d  = RUN;
                a_term_d = 1'b0;
                b_term_d = 1'b0;
            end
            RUN: begin
                // terminators are consumed before any data compare, A first
                if (a_ok && a_tz) begin
                    o_a_deq  = 1'b1;
                    a_term_d = 1'b1;
                end else if (b_ok && b_tz) begin
                    o_b_deq  = 1'b1;
                    b_term_d = 1'b1;
                end else if (a_ok && b_ok) begin
                    o_a_deq = a_le_b;
                    o_b_deq = ~a_le_b;
                    elems_d = a_le_b ? i_a_data : i_b_data;
                    sw_d    = ~a_le_b;
                    stall_d = 1'b0;
                end
                state_d = a_term_d ? DRAIN_B : b_term_d ? DRAIN_A : RUN;
            end
            DRAIN_A: if (a_ok) begin
                o_a_deq = 1'b1;
                if (a_tz) begin
                    a_term_d = 1'b1;
                    state_d  = FLUSH;
                end else begin
                    elems_d = i_a_data;
                    sw_d    = 1'b0;
                    stall_d = 1'b0;
                end
            end
            DRAIN_B: if (b_ok) begin
                o_b_deq = 1'b1;
                if (b_tz) begin
                    b_term_d = 1'b1;
                    state_d  = FLUSH;
                end else begin
                    elems_d = i_b_data;
                    sw_d    = 1'b1;
                    stall_d = 1'b0;
                end
            end
            FLUSH: if (!i_out_full) begin
                elems_d = '0;
                sw_d    = 1'b0;
                stall_d = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_term_q <= 1'b0;
            b_term_q <= 1'b0;
            elems_q  <= '0;
            stall_q  <= 1'b1;
            sw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_term_q <= a_term_d;
            b_term_q <= b_term_d;
            elems_q  <= elems_d;
            stall_q  <= stall_d;
            sw_q     <= sw_d;
        end
    end
    assign o_elems         = elems_q;
    assign o_stall         = stall_q;
    assign o_switch_output = sw_q;
    assign o_busy          = state_q inside {RUN, DRAIN_A, DRAIN_B, FLUSH};
    assign o_done          = state_q == DONE;
endmodule

// File: tb/tb_merge_2_ctrl.sv
// tb_merge_2_ctrl: directed vector table plus FIFO-model sequences for the merge issue scheduler.
module tb_merge_2_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [63:0] a_data = '0, b_data = '0;
    logic        a_empty = 1'b1, b_empty = 1'b1, out_full = 1'b0;
    logic        a_deq, b_deq, stall, sw, busy, done;
    logic [63:0] elems;
    int          checks = 0, errors = 0;

    merge_2_ctrl #(.DATA_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_a_data(a_data), .i_a_empty(a_empty), .o_a_deq(a_deq),
        .i_b_data(b_data), .i_b_empty(b_empty), .o_b_deq(b_deq),
        .i_out_full(out_full), .o_elems(elems), .o_stall(stall),
        .o_switch_output(sw), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] t(input logic [31:0] u, input logic [31:0] l);
        return {u, l};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // FIFO models: heads presented from queues, popped on a sampled dequeue strobe
    logic [63:0] qa[$], qb[$], exp_q[$];
    logic [64:0] log_q[$], exp_log[$];
    int          ia, ib, b_block;
    logic        full, last_da, last_db;

    task automatic step();
        @(negedge clk);
        a_empty  = ia >= qa.size();
        a_data   = a_empty ? 64'd0 : qa[ia];
        b_empty  = (ib >= qb.size()) || (b_block > 0);
        b_data   = b_empty ? 64'd0 : qb[ib];
        out_full = full;
        #1;
        last_da = a_deq;
        last_db = b_deq;
        @(posedge clk);
        if (last_da) ia++;
        if (last_db) ib++;
        if (b_block > 0) b_block--;
        #1;
        if (!stall) log_q.push_back({sw, elems});
    endtask

    task automatic go();
        ia = 0; ib = 0; full = 1'b0;
        log_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 65'(busy), 65'(1));
        chk("done_cleared", 65'(done), 65'(0));
    endtask

    task automatic finish_run(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        chk({name, "_done"}, 65'(done), 65'(1));
        chk({name, "_busy"}, 65'(busy), 65'(0));
        chk({name, "_a_consumed"}, 65'(ia), 65'(qa.size()));
        chk({name, "_b_consumed"}, 65'(ib), 65'(qb.size()));
        chk({name, "_count"}, 65'(log_q.size()), 65'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            chk({name, "_issue"}, log_q[i], exp_log[i]);
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic        ae, be, full, ea, eb, es;
        logic [63:0] ee;
        logic        esw;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{t(5, 3), t(6, 4), 0, 0, 0, 1, 0, 0, t(5, 3), 0};
        tbl[1] = '{t(9, 7), t(6, 4), 0, 0, 0, 0, 1, 0, t(6, 4), 1};
        tbl[2] = '{t(7, 1), t(7, 2), 0, 0, 0, 1, 0, 0, t(7, 1), 0};
        tbl[3] = '{t(1, 1), t(2, 2), 0, 0, 1, 0, 0, 1, t(7, 1), 0};
        tbl[4] = '{t(1, 1), t(2, 2), 1, 0, 0, 0, 0, 1, t(7, 1), 0};
        tbl[5] = '{t(1, 1), t(2, 2), 0, 1, 0, 0, 0, 1, t(7, 1), 0};
        tbl[6] = '{t(1, 5), t(32'h8000_0000, 0), 0, 0, 0, 1, 0, 0, t(1, 5), 0};
        tbl[7] = '{t(32'hFFFF_FFFF, 0), t(1, 9), 0, 0, 0, 0, 1, 0, t(1, 9), 1};
        tbl[8] = '{t(4, 4), t(3, 3), 0, 0, 1, 0, 0, 1, t(1, 9), 1};
        b_block = 0; full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 65'(stall), 65'(1));
        chk("rst_elems", 65'(elems), 65'(0));
        chk("rst_sw", 65'(sw), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_done", 65'(done), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        go();
        foreach (tbl[i]) begin
            @(negedge clk);
            a_data = tbl[i].a; b_data = tbl[i].b;
            a_empty = tbl[i].ae; b_empty = tbl[i].be; out_full = tbl[i].full;
            #1;
            chk($sformatf("v%0d_a_deq", i), 65'(a_deq), 65'(tbl[i].ea));
            chk($sformatf("v%0d_b_deq", i), 65'(b_deq), 65'(tbl[i].eb));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_stall", i), 65'(stall), 65'(tbl[i].es));
            chk($sformatf("v%0d_elems", i), 65'(elems), 65'(tbl[i].ee));
            chk($sformatf("v%0d_sw", i), 65'(sw), 65'(tbl[i].esw));
        end
        // asynchronous reset mid-run with both heads ready
        @(negedge clk);
        a_data = t(2, 2); b_data = t(3, 3); a_empty = 0; b_empty = 0; out_full = 0;
        #1;
        chk("pre_rst_a_deq", 65'(a_deq), 65'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_a_deq", 65'(a_deq), 65'(0));
        chk("midrst_b_deq", 65'(b_deq), 65'(0));
        chk("midrst_stall", 65'(stall), 65'(1));
        chk("midrst_busy", 65'(busy), 65'(0));
        chk("midrst_sw", 65'(sw), 65'(0));
        chk("midrst_elems", 65'(elems), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // arbitration run
        qa = '{t(5, 3), t(9, 7), t(0, 0)};
        qb = '{t(6, 4), t(8, 2), t(0, 0)};
        exp_log = '{{1'b0, t(5, 3)}, {1'b1, t(6, 4)}, {1'b1, t(8, 2)}, {1'b0, t(9, 7)}, {1'b0, 64'd0}};
        go();
        finish_run("arb");
        // back-pressure, restarted from DONE
        qa = '{t(5, 3), t(9, 7), t(0, 0)};
        qb = '{t(6, 4), t(0, 0)};
        exp_log = '{{1'b0, t(5, 3)}, {1'b1, t(6, 4)}, {1'b0, t(9, 7)}, {1'b0, 64'd0}};
        go();
        step();
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_a_deq", 65'(last_da), 65'(0));
            chk("bp_b_deq", 65'(last_db), 65'(0));
            chk("bp_stall", 65'(stall), 65'(1));
        end
        full = 1'b0;
        finish_run("bp");
        // empty A stream
        qa = '{t(0, 0)};
        qb = '{t(4, 1), t(0, 0)};
        exp_log = '{{1'b1, t(4, 1)}, {1'b0, 64'd0}};
        go();
        finish_run("emptya");
        // B starved for 4 cycles
        qa = '{t(3, 1), t(0, 0)};
        qb = '{t(2, 2), t(0, 0)};
        exp_log = '{{1'b1, t(2, 2)}, {1'b0, t(3, 1)}, {1'b0, 64'd0}};
        b_block = 4;
        go();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("starve_a_deq", 65'(last_da), 65'(0));
            chk("starve_stall", 65'(stall), 65'(1));
        end
        finish_run("starve");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
